// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states and
// the divider iteration count.
package md_pkg;

  localparam int unsigned MD_OP_W  = 3;
  localparam int unsigned DIV_ITER = 32;

  typedef enum logic [MD_OP_W-1:0] {
    OpMult  = 3'b000,
    OpMultu = 3'b001,
    OpDiv   = 3'b010,
    OpDivu  = 3'b011,
    OpMthi  = 3'b100,
    OpMtlo  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDivRun,
    StDivFix
  } md_state_e;

  // Two's-complement magnitude when the operation is signed, raw value otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/md_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_if;
  import md_pkg::*;

  logic                 start;
  logic [MD_OP_W-1:0]   md_op;
  logic [31:0]          rs_val;
  logic [31:0]          rt_val;
  logic [31:0]          hi;
  logic [31:0]          lo;
  logic                 busy;
  logic                 done;

  modport master (
    output start, md_op, rs_val, rt_val,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, md_op, rs_val, rt_val,
    output hi, lo, busy, done
  );

endinterface

// File: rtl/md_divider.sv
// 32-bit unsigned restoring divider: one quotient bit per clock after load,
// finished is high during the cycle whose closing edge performs the last step.
module md_divider
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        finished
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] shifted;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    // The dividend shifts out of the quotient register into the remainder.
    shifted  = {rem_q, quo_q[31]};
    ge       = shifted >= {1'b0, dvs_q};
    diff     = shifted[31:0] - dvs_q;
    finished = run_q && (cnt_q == 6'(DIV_ITER - 1));
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = ge ? diff : shifted[31:0];
      quo_d = {quo_q[30:0], ge};
      cnt_d = cnt_q + 6'd1;
      if (finished) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
      if (load) begin
        dvs_q <= divisor;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers; busy stalls the
// pipeline while a MULT/DIV is in flight.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned CNT_W       = 6
) (
  input  logic clk,
  input  logic rst,
  md_if.slave  bus
);

  localparam logic [CNT_W-1:0] MulLast = CNT_W'(MULT_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [31:0]      a_q, b_q;
  logic             sgn_q, qneg_q, rneg_q, dz_q, done_q;

  logic        busy, accept, mul_go, div_go, mthi_wr, mtlo_wr, mul_wr, div_wr;
  logic        sgn_op, div_fin;
  logic [63:0] prod;
  logic [31:0] div_a, div_b, quo, rem, quo_fix, rem_fix;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mul_go) begin
          state_d = StMul;
        end else if (div_go) begin
          state_d = StDivRun;
        end
      end
      StMul:    if (mul_wr) state_d = StIdle;
      StDivRun: if (div_fin) state_d = StDivFix;
      StDivFix: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Control outputs; requests are only seen while idle.
  always_comb begin
    busy    = state_q != StIdle;
    accept  = bus.start && !busy;
    mul_go  = accept && (bus.md_op == OpMult || bus.md_op == OpMultu);
    div_go  = accept && (bus.md_op == OpDiv || bus.md_op == OpDivu);
    mthi_wr = accept && (bus.md_op == OpMthi);
    mtlo_wr = accept && (bus.md_op == OpMtlo);
    mul_wr  = (state_q == StMul) && (cnt_q == MulLast);
    div_wr  = state_q == StDivFix;
  end

  assign sgn_op = (bus.md_op == OpMult) || (bus.md_op == OpDiv);
  assign div_a  = abs32(bus.rs_val, sgn_op);
  assign div_b  = abs32(bus.rt_val, sgn_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == StIdle) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Operands and sign bookkeeping captured on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      sgn_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
    end else if (mul_go || div_go) begin
      a_q    <= bus.rs_val;
      b_q    <= bus.rt_val;
      sgn_q  <= sgn_op;
      qneg_q <= sgn_op && (bus.rs_val[31] ^ bus.rt_val[31]);
      rneg_q <= sgn_op && bus.rs_val[31];
      dz_q   <= bus.rt_val == '0;
    end
  end

  assign prod = sgn_q ? ({{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q})
                      : ({32'd0, a_q} * {32'd0, b_q});

  md_divider u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_go),
    .dividend (div_a),
    .divisor  (div_b),
    .quotient (quo),
    .remainder(rem),
    .finished (div_fin)
  );

  assign quo_fix = qneg_q ? (~quo + 32'd1) : quo;
  assign rem_fix = rneg_q ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= mul_wr || div_wr;
      if (mthi_wr) begin
        hi_q <= bus.rs_val;
      end
      if (mtlo_wr) begin
        lo_q <= bus.rs_val;
      end
      if (mul_wr) begin
        {hi_q, lo_q} <= prod;
      end
      if (div_wr) begin
        // Divide by zero returns the raw dividend regardless of signedness.
        {hi_q, lo_q} <= dz_q ? {a_q, 32'hFFFF_FFFF} : {rem_fix, quo_fix};
      end
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy;
  assign bus.done = done_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed and randomized bench for md_unit against an arithmetic HI/LO model.
module tb_md_unit;

  localparam int unsigned MulCycles = 5;
  localparam int unsigned DivCycles = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  md_if bus ();

  md_unit #(
    .MULT_CYCLES(MulCycles),
    .CNT_W      (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {hi,lo} after op, straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    longint sa, sb;
    int     qa, qb;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2, 3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 3'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = int'(a);
        qb = int'(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
      3'd4:    return {a, l};
      3'd5:    return {h, a};
      default: return {h, l};
    endcase
  endfunction

  task automatic wait_idle(output int n, output logic early_done);
    n = 0;
    early_done = 1'b0;
    while (bus.busy === 1'b1 && n < 200) begin
      if (bus.done !== 1'b0) early_done = 1'b1;
      step();
      n++;
    end
  endtask

  // MULT/MULTU/DIV/DIVU; operands are scrambled after acceptance.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    int          n;
    logic        ed;
    e = model(op, a, b, exp_hi, exp_lo);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    step();
    bus.start  = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    chk("busy_after_accept", 32'(bus.busy), 32'd1);
    wait_idle(n, ed);
    chk($sformatf("latency op%0d", op), 32'(n), (op < 3'd2) ? MulCycles : DivCycles);
    chk("done_during_busy", 32'(ed), 32'd0);
    chk("done_pulse", 32'(bus.done), 32'd1);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    chk($sformatf("hi op%0d a=%h b=%h", op, a, b), bus.hi, exp_hi);
    chk($sformatf("lo op%0d a=%h b=%h", op, a, b), bus.lo, exp_lo);
  endtask

  // MTHI/MTLO and no-op codes: single-cycle, never busy.
  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    logic [63:0] e;
    e = model(op, a, 32'd0, exp_hi, exp_lo);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = $urandom;
    step();
    bus.start = 1'b0;
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    chk($sformatf("mt hi op%0d", op), bus.hi, exp_hi);
    chk($sformatf("mt lo op%0d", op), bus.lo, exp_lo);
    chk("mt busy", 32'(bus.busy), 32'd0);
    chk("mt done", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int          n;
    logic        ed;
    logic        bad;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] e;

    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;

    #1 rst = 1'b1;
    #1;
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    step();
    step();
    rst = 1'b0;

    mt(3'd4, 32'hA5A5_A5A5);
    mt(3'd5, 32'h5A5A_5A5A);

    // Asynchronous reset between edges clears state with no clock edge.
    #3 rst = 1'b1;
    #1;
    chk("async_rst hi", bus.hi, 32'd0);
    chk("async_rst lo", bus.lo, 32'd0);
    chk("async_rst busy", 32'(bus.busy), 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    #1 rst = 1'b0;
    step();

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult const hi", bus.hi, 32'hFFFF_FFFF);
    chk("mult const lo", bus.lo, 32'hFFFF_FFFA);
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    chk("multu const hi", bus.hi, 32'h0000_0002);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div const lo", bus.lo, 32'hFFFF_FFFD);
    chk("div const hi", bus.hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd100, 32'd7);
    chk("divu const lo", bus.lo, 32'd14);
    run_op(3'd3, 32'd100, 32'd0);
    chk("divu0 const hi", bus.hi, 32'd100);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div ovf const lo", bus.lo, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FF00, 32'd0);
    step();
    chk("done one cycle", 32'(bus.done), 32'd0);

    // Requests during a DIV are ignored entirely.
    e = model(3'd2, 32'd12345, 32'hFFFF_FFF0, exp_hi, exp_lo);
    bus.start  = 1'b1;
    bus.md_op  = 3'd2;
    bus.rs_val = 32'd12345;
    bus.rt_val = 32'hFFFF_FFF0;
    step();
    bus.md_op  = 3'd5;
    bus.rs_val = 32'h0000_DEAD;
    bus.rt_val = 32'd1;
    repeat (10) step();
    bus.start = 1'b0;
    wait_idle(n, ed);
    chk("ignored latency", 32'(n + 10), DivCycles);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    chk("ignored hi", bus.hi, exp_hi);
    chk("ignored lo", bus.lo, exp_lo);

    // Reset at cycle 10 of a DIV aborts it without a done pulse.
    bus.start  = 1'b1;
    bus.md_op  = 3'd2;
    bus.rs_val = 32'd1000;
    bus.rt_val = 32'd3;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    #1 rst = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      step();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) bad = 1'b1;
    end
    chk("abort no done", 32'(bad), 32'd0);
    mt(3'd4, 32'h0000_1234);

    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       a = 32'h8000_0000;
        default: ;
      endcase
      if (op < 3'd4) run_op(op, a, b);
      else mt(op, a);
    end
    step();
    chk("final done", 32'(bus.done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
